// File: rtl/thread_scheduler.sv
// -----------------------------------------------------------------------------
// thread_scheduler
//
// Round-robin thread dispatcher for the multi-CPU core. New process handles
// enter a pending FIFO through the spawn port. On each CPU-loop request the
// scheduler either promotes the FIFO head into the lowest free active slot or,
// when nothing can be promoted, rotates to the next valid active slot after the
// round-robin pointer. Handles leave the active table through the kill port.
//
// Parameters
//   DATA_W       width of a process handle
//   MAX_THREADS  depth of the pending FIFO and of the active slot table
//                (power of two, at least 2)
//   BOOT_ID      handle seeded into the pending FIFO at reset
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   spawn_valid  enqueue request for spawn_id
//   spawn_id     handle to enqueue
//   spawn_ready  pending FIFO not full (from the registered count)
//   kill_valid   retire every active slot holding kill_id
//   kill_id      handle to retire
//   kill_miss    one-cycle pulse: the last kill matched no active slot
//   next_req     dispatch request from the CPU loop
//   next_valid   one-cycle pulse: next_proc holds a new dispatch
//   next_proc    dispatched handle, held between dispatches
//   active_cnt   number of occupied active slots
//   pending_cnt  number of entries in the pending FIFO
//   idle         no active and no pending handles
//
// Optional build macro THREAD_SCHED_STATS_EN adds:
//   switch_cnt   [31:0] number of next_valid pulses since reset (wraps)
//   promote_cnt  [31:0] number of FIFO-to-slot promotions since reset (wraps)
// -----------------------------------------------------------------------------
module thread_scheduler #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       MAX_THREADS = 8,
  parameter logic [DATA_W-1:0] BOOT_ID     = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spawn_valid,
  input  logic [DATA_W-1:0]             spawn_id,
  output logic                          spawn_ready,
  input  logic                          kill_valid,
  input  logic [DATA_W-1:0]             kill_id,
  output logic                          kill_miss,
  input  logic                          next_req,
  output logic                          next_valid,
  output logic [DATA_W-1:0]             next_proc,
  output logic [$clog2(MAX_THREADS):0]  active_cnt,
  output logic [$clog2(MAX_THREADS):0]  pending_cnt,
`ifdef THREAD_SCHED_STATS_EN
  output logic [31:0]                   switch_cnt,
  output logic [31:0]                   promote_cnt,
`endif
  output logic                          idle
);

  localparam int unsigned PTR_W = $clog2(MAX_THREADS);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_THREADS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]      fifo_q [MAX_THREADS];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q;
  logic [CNT_W-1:0]       pending_cnt_q, pending_cnt_d;

  logic [DATA_W-1:0]      slot_q [MAX_THREADS];
  logic [MAX_THREADS-1:0] slot_vld_q, slot_vld_d;
  logic [CNT_W-1:0]       active_cnt_q, active_cnt_d;
  logic [PTR_W-1:0]       rr_q, rr_d;

  logic                   next_valid_q, next_valid_d;
  logic [DATA_W-1:0]      next_proc_q, next_proc_d;
  logic                   kill_miss_q, kill_miss_d;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [MAX_THREADS-1:0] kill_hit;
  logic [MAX_THREADS-1:0] vld_live;  // valid mask after this cycle's kill
  logic                   push;
  logic                   promote;
  logic                   rotate;
  logic [PTR_W-1:0]       free_idx;
  logic [PTR_W-1:0]       rr_idx;
  logic [PTR_W-1:0]       rr_sel;

  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_THREADS-1:0] m);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_THREADS; i++) n = n + CNT_W'(m[i]);
    return n;
  endfunction

  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    kill_hit = '0;
    for (int i = 0; i < MAX_THREADS; i++) begin
      kill_hit[i] = kill_valid && slot_vld_q[i] && (slot_q[i] == kill_id);
    end
  end

  // Kill is applied before selection, so a killed handle is never dispatched
  // and its slot can take a promotion in the same cycle.
  assign vld_live    = slot_vld_q & ~kill_hit;
  assign kill_miss_d = kill_valid && (kill_hit == '0);

  // Ready comes only from the registered count: a pop in the same cycle does
  // not open room for a spawn on a full FIFO.
  assign spawn_ready = (pending_cnt_q != CNT_FULL);
  assign push        = spawn_valid && spawn_ready;

  // Promotion uses the registered pending count, so a handle spawned into an
  // empty FIFO waits for the following request.
  assign promote = next_req && (pending_cnt_q != '0) && !(&vld_live);
  assign rotate  = next_req && !promote && (|vld_live);

  // Lowest-index free slot: scanning downward leaves the smallest index last.
  always_comb begin
    free_idx = '0;
    for (int i = MAX_THREADS - 1; i >= 0; i--) begin
      if (!vld_live[i]) free_idx = PTR_W'(i);
    end
  end

  // First valid slot strictly after rr, wrapping. The offset MAX_THREADS
  // truncates to rr itself, so a lone valid slot is re-chosen. Scanning the
  // offsets downward leaves the nearest hit in rr_sel.
  always_comb begin
    rr_sel = rr_q;
    rr_idx = '0;
    for (int k = MAX_THREADS; k >= 1; k--) begin
      rr_idx = rr_q + PTR_W'(k);
      if (vld_live[rr_idx]) rr_sel = rr_idx;
    end
  end

  always_comb begin
    slot_vld_d   = vld_live;
    rr_d         = rr_q;
    head_d       = head_q;
    next_valid_d = 1'b0;
    next_proc_d  = next_proc_q;
    if (promote) begin
      slot_vld_d[free_idx] = 1'b1;
      rr_d                 = free_idx;
      head_d               = head_q + PTR_ONE;
      next_valid_d         = 1'b1;
      next_proc_d          = fifo_q[head_q];
    end else if (rotate) begin
      rr_d         = rr_sel;
      next_valid_d = 1'b1;
      next_proc_d  = slot_q[rr_sel];
    end
  end

  assign pending_cnt_d = pending_cnt_q + CNT_W'(push) - CNT_W'(promote);
  assign active_cnt_d  = popcount(slot_vld_d);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= PTR_ONE;
      pending_cnt_q <= CNT_ONE;
      slot_vld_q    <= '0;
      active_cnt_q  <= '0;
      rr_q          <= '0;
      next_valid_q  <= 1'b0;
      next_proc_q   <= '0;
      kill_miss_q   <= 1'b0;
    end else begin
      head_q        <= head_d;
      if (push) tail_q <= tail_q + PTR_ONE;
      pending_cnt_q <= pending_cnt_d;
      slot_vld_q    <= slot_vld_d;
      active_cnt_q  <= active_cnt_d;
      rr_q          <= rr_d;
      next_valid_q  <= next_valid_d;
      next_proc_q   <= next_proc_d;
      kill_miss_q   <= kill_miss_d;
    end
  end

  // NOTE: the handle storage arrays are not cleared on reset; the valid mask
  // and the FIFO count decide which entries mean anything. Only the boot
  // entry is written, because the FIFO comes out of reset holding it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0] <= BOOT_ID;
    end else if (push) begin
      fifo_q[tail_q] <= spawn_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && promote) begin
      slot_q[free_idx] <= fifo_q[head_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef THREAD_SCHED_STATS_EN
  logic [31:0] switch_cnt_q;
  logic [31:0] promote_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      switch_cnt_q  <= '0;
      promote_cnt_q <= '0;
    end else begin
      // Counts on the same edge that raises next_valid.
      if (next_valid_d) switch_cnt_q  <= switch_cnt_q + 32'd1;
      if (promote)      promote_cnt_q <= promote_cnt_q + 32'd1;
    end
  end

  assign switch_cnt  = switch_cnt_q;
  assign promote_cnt = promote_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign next_valid  = next_valid_q;
  assign next_proc   = next_proc_q;
  assign kill_miss   = kill_miss_q;
  assign active_cnt  = active_cnt_q;
  assign pending_cnt = pending_cnt_q;
  assign idle        = (active_cnt_q == '0) && (pending_cnt_q == '0);

endmodule

// File: tb/tb_thread_scheduler.sv
// -----------------------------------------------------------------------------
// tb_thread_scheduler
//
// Directed bench for thread_scheduler (DATA_W=32, MAX_THREADS=8, BOOT_ID=0).
// Each dispatch request pushes its hand-computed handle into exp_q; a monitor
// on the falling edge pops and compares whenever next_valid is high, and flags
// any dispatch nobody asked for. Counts, flags and the reset state are checked
// directly by the stimulus process on falling edges.
// -----------------------------------------------------------------------------
module tb_thread_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        spawn_valid;
  logic [31:0] spawn_id;
  logic        spawn_ready;
  logic        kill_valid;
  logic [31:0] kill_id;
  logic        kill_miss;
  logic        next_req;
  logic        next_valid;
  logic [31:0] next_proc;
  logic [3:0]  active_cnt;
  logic [3:0]  pending_cnt;
  logic        idle;
`ifdef THREAD_SCHED_STATS_EN
  logic [31:0] switch_cnt;
  logic [31:0] promote_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  thread_scheduler #(
    .DATA_W      (32),
    .MAX_THREADS (8),
    .BOOT_ID     (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spawn_valid (spawn_valid),
    .spawn_id    (spawn_id),
    .spawn_ready (spawn_ready),
    .kill_valid  (kill_valid),
    .kill_id     (kill_id),
    .kill_miss   (kill_miss),
    .next_req    (next_req),
    .next_valid  (next_valid),
    .next_proc   (next_proc),
    .active_cnt  (active_cnt),
    .pending_cnt (pending_cnt),
`ifdef THREAD_SCHED_STATS_EN
    .switch_cnt  (switch_cnt),
    .promote_cnt (promote_cnt),
`endif
    .idle        (idle)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: outputs are all registered, so the falling edge is a
  // stable sampling point.
  always @(negedge clk) begin
    if (next_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_dispatch", 32'(next_valid), 32'd0);
      end else begin
        check("dispatch", next_proc, exp_q.pop_front());
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic dispatch(input logic [31:0] exp);
    exp_q.push_back(exp);
    next_req = 1'b1;
    cycle();
    next_req = 1'b0;
  endtask

  task automatic spawn(input logic [31:0] id);
    check("spawn_ready_before_spawn", 32'(spawn_ready), 32'd1);
    spawn_valid = 1'b1;
    spawn_id    = id;
    cycle();
    spawn_valid = 1'b0;
  endtask

  task automatic kill(input logic [31:0] id);
    kill_valid = 1'b1;
    kill_id    = id;
    cycle();
    kill_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pending_cnt"}, 32'(pending_cnt), 32'd1);
    check({tag, "_active_cnt"},  32'(active_cnt),  32'd0);
    check({tag, "_idle"},        32'(idle),        32'd0);
    check({tag, "_spawn_ready"}, 32'(spawn_ready), 32'd1);
    check({tag, "_next_valid"},  32'(next_valid),  32'd0);
    check({tag, "_next_proc"},   next_proc,        32'd0);
    check({tag, "_kill_miss"},   32'(kill_miss),   32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    spawn_valid = 1'b0;
    spawn_id    = '0;
    kill_valid  = 1'b0;
    kill_id     = '0;
    next_req    = 1'b0;
    cycle();
    cycle();
    check_reset_state("reset");
    rst = 1'b0;

    // 1: boot handle promoted, then re-chosen as the lone active slot.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0);
      next_req = 1'b1;
      cycle();
    end
    next_req = 1'b0;
    check("t1_active_cnt",  32'(active_cnt),  32'd1);
    check("t1_pending_cnt", 32'(pending_cnt), 32'd0);

    // 2: promotions first, then round-robin after rr: 5, 6, 0, 5.
    spawn(32'h5);
    spawn(32'h6);
    check("t2_pending_cnt", 32'(pending_cnt), 32'd2);
    dispatch(32'h5);
    dispatch(32'h6);
    dispatch(32'h0);
    dispatch(32'h5);
    check("t2_active_cnt",  32'(active_cnt),  32'd3);
    check("t2_pending_cnt_after", 32'(pending_cnt), 32'd0);

    // 4: rr on the slot of 5; kill 6 with a request skips 6 and wraps to 0.
    exp_q.push_back(32'h0);
    kill_valid = 1'b1;
    kill_id    = 32'h6;
    next_req   = 1'b1;
    cycle();
    kill_valid = 1'b0;
    next_req   = 1'b0;
    check("t4_active_cnt", 32'(active_cnt), 32'd2);
    check("t4_kill_miss",  32'(kill_miss),  32'd0);

    // 5: kill of an absent handle pulses kill_miss for exactly one cycle.
    kill(32'h99);
    check("t5_kill_miss_pulse", 32'(kill_miss),  32'd1);
    check("t5_active_cnt",      32'(active_cnt), 32'd2);
    cycle();
    check("t5_kill_miss_clear", 32'(kill_miss),  32'd0);
    check("t5_next_proc_hold",  next_proc,       32'd0);

    // 6: empty everything; a request then produces no dispatch.
    kill(32'h0);
    check("t6_kill0_miss", 32'(kill_miss), 32'd0);
    kill(32'h5);
    check("t6_active_cnt", 32'(active_cnt), 32'd0);
    check("t6_idle",       32'(idle),       32'd1);
    next_req = 1'b1;
    cycle();
    next_req = 1'b0;
    check("t6_no_dispatch", 32'(next_valid), 32'd0);
    check("t6_idle_after",  32'(idle),       32'd1);

    // Spawn into an empty FIFO together with a request: not promoted yet.
    spawn_valid = 1'b1;
    spawn_id    = 32'h42;
    next_req    = 1'b1;
    cycle();
    spawn_valid = 1'b0;
    next_req    = 1'b0;
    check("t6_spawn_no_promote", 32'(next_valid),  32'd0);
    check("t6_spawn_pending",    32'(pending_cnt), 32'd1);
    dispatch(32'h42);

    // Reset during a dispatch request wins over the request.
    rst      = 1'b1;
    next_req = 1'b1;
    cycle();
    next_req = 1'b0;
    check_reset_state("midrst");
    rst = 1'b0;

    // 3: boot entry plus seven spawns fill the FIFO; the eighth is refused,
    // even when a promotion pops in the same cycle.
    for (int i = 0; i < 7; i++) spawn(32'h10 + 32'(i));
    check("t3_pending_full", 32'(pending_cnt), 32'd8);
    check("t3_ready_full",   32'(spawn_ready), 32'd0);
    exp_q.push_back(32'h0);
    spawn_valid = 1'b1;
    spawn_id    = 32'h17;
    next_req    = 1'b1;
    cycle();
    spawn_valid = 1'b0;
    next_req    = 1'b0;
    check("t3_pending_after_pop", 32'(pending_cnt), 32'd7);
    check("t3_ready_after_pop",   32'(spawn_ready), 32'd1);
    for (int i = 0; i < 7; i++) dispatch(32'h10 + 32'(i));
    check("t3_active_full",  32'(active_cnt),  32'd8);
    check("t3_pending_zero", 32'(pending_cnt), 32'd0);
    // Table full: rotation wraps from slot 7 back to slot 0.
    dispatch(32'h0);
    // Pending entry but no free slot: rotation continues to slot 1.
    spawn(32'h20);
    dispatch(32'h10);
    // Kill frees slot 3 in the same cycle, so 0x20 is promoted into it.
    exp_q.push_back(32'h20);
    kill_valid = 1'b1;
    kill_id    = 32'h12;
    next_req   = 1'b1;
    cycle();
    kill_valid = 1'b0;
    next_req   = 1'b0;
    check("t3_kill_promote_active",  32'(active_cnt),  32'd8);
    check("t3_kill_promote_pending", 32'(pending_cnt), 32'd0);
    check("t3_kill_promote_miss",    32'(kill_miss),   32'd0);

    cycle();
    cycle();
    check("dispatch_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
